fpu_arbiter: RTL and testbench
==============================

// Module: fpu_arbiter
// PURPOSE
//  Shares the single fpu add datapath between NUM_REQ requesters (UART host ctrl, program sequencer, ...).
//  Round-robin picks one request, latches its operands, pulses fpu add, waits for fpu idle, returns result.
//  Sits between the requesters and fpu; sole driver of the fpu operand/add inputs.
// PARAMETERS
//  NUM_REQ   2    number of requesters, legal 2..4
//  EXP_W     7    exponent width (matches fpu reg*_e)
//  MAN_W     15   mantissa width (matches fpu reg*_m)
//  GUARD     2    cycles after add pulse during which fpu_idle is ignored, legal 1..7
//  TIMEOUT   255  max BUSY cycles before abort (only with FPU_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1                clock
//  reset      in   1                asynchronous, active-high reset
//  req        in   NUM_REQ          request i; hold with operands stable until grant[i]
//  req_ae     in   NUM_REQ*EXP_W    operand A exponent, slice i
//  req_am     in   NUM_REQ*MAN_W    operand A mantissa, slice i
//  req_be     in   NUM_REQ*EXP_W    operand B exponent, slice i
//  req_bm     in   NUM_REQ*MAN_W    operand B mantissa, slice i
//  grant      out  NUM_REQ          one-hot, 1-cycle accept pulse
//  rsp_valid  out  NUM_REQ          one-hot, 1-cycle result pulse to owning requester
//  rsp_e      out  EXP_W            result exponent, valid while any rsp_valid
//  rsp_m      out  MAN_W            result mantissa, valid while any rsp_valid
//  rsp_err    out  1                timeout flag, valid with rsp_valid
//  busy       out  1                high in every state except IDLE
//  fpu_add    out  1                1-cycle start pulse to fpu
//  fpu_r1e/fpu_r1m/fpu_r2e/fpu_r2m  out  EXP_W/MAN_W  latched operands, stable from grant to next grant
//  fpu_res_e/fpu_res_m  in  EXP_W/MAN_W  fpu result
//  fpu_idle   in   1                fpu idle
// BEHAVIOUR
//  Reset (async): state IDLE; grant, rsp_valid, rsp_err, busy, fpu_add, all operand/result regs = 0; rr pointer = 0.
//  All outputs registered. States: IDLE -> ISSUE -> GUARD -> BUSY -> DONE -> IDLE.
//  IDLE: if any req at edge T, pick first set bit searching from ptr upward (wrap); at edge T: latch its operands,
//   grant[i]=1, fpu_add=1, owner=i, ptr=(i+1) mod NUM_REQ, -> ISSUE. No req: stay.
//  ISSUE (1 cycle, grant and fpu_add high): -> GUARD, counter loaded GUARD-1.
//  GUARD: fpu_idle ignored; count down; at 0 -> BUSY.
//  BUSY: on fpu_idle=1 capture fpu_res_e/m, rsp_err=0 -> DONE.
//  DONE (1 cycle): rsp_valid[owner]=1 with rsp_e/m/err; -> IDLE. Min req-to-rsp latency 3+GUARD cycles.
//  Arbitration only in IDLE; req during ISSUE..DONE waits. Req dropped before grant = withdrawn, no effect.
//  Req dropped after grant: operation completes, rsp_valid still issued. Owner may re-request in DONE cycle;
//   earliest regrant is edge after IDLE entry, and ptr guarantees others win first if pending.
//  Reset mid-operation: immediate IDLE, no rsp_valid ever issued for the aborted op.
//  Requests beyond NUM_REQ bits do not exist; ptr wraps NUM_REQ-1 -> 0.
// CONFIGURATION
//  FPU_ARB_TIMEOUT_EN defined: BUSY counts cycles; at TIMEOUT cycles without fpu_idle -> DONE with
//   rsp_e=0, rsp_m=0, rsp_err=1. Undefined: BUSY waits indefinitely; rsp_err tied 0, no counter logic.
// STRUCTURE
//  Shared include fpu_defs.vh: EXP_W/MAN_W defaults, arbiter state encodings (3-bit), fpu command bytes.
//  Sub-module rr_pick: combinational round-robin one-hot picker (req, ptr -> onehot, index, any).
// TESTING (bench fpu model: idle drops 1 cycle after add, rises 8 cycles later, result = A+B on mantissa)
//  1. req[0] only, A=(7'h01,15'h1000) B=(7'h01,15'h0800) -> grant[0] next edge, one fpu_add, rsp_valid[0] with m=15'h1800, err=0.
//  2. req=2'b11 held constantly -> grants alternate 0,1,0,1; each rsp_valid to matching owner; 4 ops, 4 fpu_add pulses.
//  3. req[1] raised during BUSY of op 0 -> not granted until after rsp_valid[0]; grant[1] on first IDLE edge.
//  4. reset asserted in BUSY -> all outputs 0 same cycle (async), no rsp_valid; after release req[0] serviced normally.
//  5. FPU_ARB_TIMEOUT_EN, TIMEOUT=20, model holds idle low -> rsp_valid with err=1, rsp_e=0, rsp_m=0 after 20 BUSY cycles.
//  6. req[0] pulsed 1 cycle while arbiter busy then dropped -> never granted; no spurious rsp_valid.

Source files
------------

// File: rtl/fpu_arbiter_pkg.sv
// rtl/fpu_arbiter_pkg.sv - shared widths and arbiter state encodings for the fpu arbiter
package fpu_arbiter_pkg;

  localparam int EXP_W_DEF = 7;
  localparam int MAN_W_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GUARD = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/fpu_arbiter_if.sv
// rtl/fpu_arbiter_if.sv - requester and fpu side signals of the fpu arbiter
interface fpu_arbiter_if
  import fpu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int EXP_W   = EXP_W_DEF,
  parameter int MAN_W   = MAN_W_DEF
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*EXP_W-1:0] req_ae;
  logic [NUM_REQ*MAN_W-1:0] req_am;
  logic [NUM_REQ*EXP_W-1:0] req_be;
  logic [NUM_REQ*MAN_W-1:0] req_bm;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [EXP_W-1:0]         rsp_e;
  logic [MAN_W-1:0]         rsp_m;
  logic                     rsp_err;
  logic                     busy;
  logic                     fpu_add;
  logic [EXP_W-1:0]         fpu_r1e;
  logic [MAN_W-1:0]         fpu_r1m;
  logic [EXP_W-1:0]         fpu_r2e;
  logic [MAN_W-1:0]         fpu_r2m;
  logic [EXP_W-1:0]         fpu_res_e;
  logic [MAN_W-1:0]         fpu_res_m;
  logic                     fpu_idle;

  modport master (
    output req, req_ae, req_am, req_be, req_bm, fpu_res_e, fpu_res_m, fpu_idle,
    input  grant, rsp_valid, rsp_e, rsp_m, rsp_err, busy,
           fpu_add, fpu_r1e, fpu_r1m, fpu_r2e, fpu_r2m
  );

  modport slave (
    input  req, req_ae, req_am, req_be, req_bm, fpu_res_e, fpu_res_m, fpu_idle,
    output grant, rsp_valid, rsp_e, rsp_m, rsp_err, busy,
           fpu_add, fpu_r1e, fpu_r1m, fpu_r2e, fpu_r2m
  );

endinterface

// File: rtl/fpu_arbiter_rr_pick.sv
// rtl/fpu_arbiter_rr_pick.sv - combinational round-robin picker, first request at or above ptr with wrap
module fpu_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  always_comb begin
    int j;
    onehot = '0;
    index  = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        index     = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin sharing of the fpu add datapath between NUM_REQ requesters
// FPU_ARB_TIMEOUT_EN adds a BUSY-state abort after TIMEOUT cycles, flagged on rsp_err.
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int EXP_W   = EXP_W_DEF,
  parameter int MAN_W   = MAN_W_DEF,
  parameter int GUARD   = 2
`ifdef FPU_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic         clk,
  input  logic         reset,
  fpu_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state, state_d;
  logic [IDX_W-1:0]   ptr, owner;
  logic [2:0]         gcnt;
  logic [NUM_REQ-1:0] pick_onehot, grant_d, rsp_valid_d;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
`ifdef FPU_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]    to_cnt;
  logic               to_hit;
  assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));
`endif

  fpu_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      owner         <= '0;
      gcnt          <= '0;
      bus.grant     <= '0;
      bus.rsp_valid <= '0;
      bus.busy      <= 1'b0;
      bus.fpu_add   <= 1'b0;
      bus.fpu_r1e   <= '0;
      bus.fpu_r1m   <= '0;
      bus.fpu_r2e   <= '0;
      bus.fpu_r2m   <= '0;
      bus.rsp_e     <= '0;
      bus.rsp_m     <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      bus.rsp_err   <= 1'b0;
      to_cnt        <= '0;
`endif
    end else begin
      state         <= state_d;
      bus.grant     <= grant_d;
      bus.fpu_add   <= |grant_d;
      bus.rsp_valid <= rsp_valid_d;
      bus.busy      <= (state_d != ST_IDLE);
      case (state)
        ST_IDLE: if (pick_any) begin
          bus.fpu_r1e <= bus.req_ae[int'(pick_idx)*EXP_W +: EXP_W];
          bus.fpu_r1m <= bus.req_am[int'(pick_idx)*MAN_W +: MAN_W];
          bus.fpu_r2e <= bus.req_be[int'(pick_idx)*EXP_W +: EXP_W];
          bus.fpu_r2m <= bus.req_bm[int'(pick_idx)*MAN_W +: MAN_W];
          owner       <= pick_idx;
          ptr         <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
        ST_ISSUE: begin
          gcnt <= 3'(GUARD - 1);
`ifdef FPU_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        ST_GUARD: if (gcnt != 3'd0) gcnt <= gcnt - 3'd1;
        ST_BUSY: begin
          if (bus.fpu_idle) begin
            bus.rsp_e <= bus.fpu_res_e;
            bus.rsp_m <= bus.fpu_res_m;
`ifdef FPU_ARB_TIMEOUT_EN
            bus.rsp_err <= 1'b0;
          end else if (to_hit) begin
            bus.rsp_e   <= '0;
            bus.rsp_m   <= '0;
            bus.rsp_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifndef FPU_ARB_TIMEOUT_EN
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_GUARD;
      ST_GUARD: if (gcnt == 3'd0) state_d = ST_BUSY;
`ifdef FPU_ARB_TIMEOUT_EN
      ST_BUSY:  if (bus.fpu_idle || to_hit) state_d = ST_DONE;
`else
      ST_BUSY:  if (bus.fpu_idle) state_d = ST_DONE;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead and registered alongside the state.
  always_comb begin
    grant_d     = '0;
    rsp_valid_d = '0;
    if (state == ST_IDLE && pick_any) grant_d = pick_onehot;
    if (state == ST_BUSY && state_d == ST_DONE) rsp_valid_d = NUM_REQ'(1) << owner;
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - directed self-checking bench for fpu_arbiter with a behavioural fpu model
module tb_fpu_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fpu_arbiter_if #(.NUM_REQ(2), .EXP_W(7), .MAN_W(15)) bus ();

`ifdef FPU_ARB_TIMEOUT_EN
  fpu_arbiter #(.NUM_REQ(2), .EXP_W(7), .MAN_W(15), .GUARD(2), .TIMEOUT(20)) dut (
`else
  fpu_arbiter #(.NUM_REQ(2), .EXP_W(7), .MAN_W(15), .GUARD(2)) dut (
`endif
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass = 0;
  int add_cnt = 0;
  int rsp_cnt = 0;
  int grant_cnt = 0;
  logic hold_low = 1'b0;
  logic [3:0] fcnt;

  // fpu model: idle drops the cycle after add, stays low 8 cycles, result = A+B on mantissa
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.fpu_idle  <= 1'b1;
      fcnt          <= '0;
      bus.fpu_res_e <= '0;
      bus.fpu_res_m <= '0;
    end else if (bus.fpu_add) begin
      bus.fpu_idle  <= 1'b0;
      fcnt          <= 4'd7;
      bus.fpu_res_e <= bus.fpu_r1e;
      bus.fpu_res_m <= bus.fpu_r1m + bus.fpu_r2m;
    end else if (!bus.fpu_idle && !hold_low) begin
      if (fcnt == 4'd0) bus.fpu_idle <= 1'b1;
      else fcnt <= fcnt - 4'd1;
    end
  end

  always @(negedge clk) begin
    if (bus.fpu_add) add_cnt++;
    if (|bus.rsp_valid) rsp_cnt++;
    if (|bus.grant) grant_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // which: 0 = any grant, 1 = any rsp_valid; cyc = edges waited, -1 on expiry
  task automatic wait_evt(input int which, input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if ((which == 0 && |bus.grant) || (which == 1 && |bus.rsp_valid)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic set_ops(input int idx, input logic [6:0] ae, input logic [14:0] am,
                         input logic [6:0] be, input logic [14:0] bm);
    bus.req_ae[idx*7 +: 7]   = ae;
    bus.req_am[idx*15 +: 15] = am;
    bus.req_be[idx*7 +: 7]   = be;
    bus.req_bm[idx*15 +: 15] = bm;
  endtask

  initial begin
    int cyc;
    int base_add;
    int base_rsp;
    int base_grant;
    bus.req = '0;
    bus.req_ae = '0;
    bus.req_am = '0;
    bus.req_be = '0;
    bus.req_bm = '0;
    step(2);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_add", 32'(bus.fpu_add), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    check("rst_r1m", 32'(bus.fpu_r1m), 0);
    reset = 1'b0;
    step(1);

    // 1: single request, A+B mantissa
    set_ops(0, 7'h01, 15'h1000, 7'h01, 15'h0800);
    bus.req = 2'b01;
    base_add = add_cnt;
    wait_evt(0, 5, cyc);
    check("t1_grant_lat", 32'(cyc), 1);
    check("t1_grant", 32'(bus.grant), 32'h1);
    check("t1_add", 32'(bus.fpu_add), 1);
    check("t1_busy", 32'(bus.busy), 1);
    check("t1_r1m", 32'(bus.fpu_r1m), 32'h1000);
    check("t1_r2m", 32'(bus.fpu_r2m), 32'h0800);
    bus.req = 2'b00;
    wait_evt(1, 40, cyc);
    check("t1_rsp_lat", 32'(cyc), 10);
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t1_rsp_m", 32'(bus.rsp_m), 32'h1800);
    check("t1_rsp_e", 32'(bus.rsp_e), 32'h01);
    check("t1_rsp_err", 32'(bus.rsp_err), 0);
    check("t1_add_cnt", 32'(add_cnt - base_add), 1);
    step(1);
    check("t1_rsp_pulse", 32'(bus.rsp_valid), 0);
    check("t1_idle_busy", 32'(bus.busy), 0);

    // 2: both held after reset, grants alternate 0,1,0,1
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    set_ops(0, 7'h02, 15'h0100, 7'h02, 15'h0001);
    set_ops(1, 7'h03, 15'h0200, 7'h03, 15'h0002);
    base_add = add_cnt;
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_evt(0, 10, cyc);
      check("t2_grant_found", 32'(cyc > 0), 1);
      check("t2_grant", 32'(bus.grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k == 3) bus.req = 2'b00;
      wait_evt(1, 40, cyc);
      check("t2_rsp_valid", 32'(bus.rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("t2_rsp_m", 32'(bus.rsp_m), (k % 2 == 0) ? 32'h0101 : 32'h0202);
    end
    check("t2_add_cnt", 32'(add_cnt - base_add), 4);

    // 3: req[1] arrives during BUSY of op 0, granted on first IDLE edge
    step(2);
    bus.req = 2'b01;
    wait_evt(0, 5, cyc);
    check("t3_grant0", 32'(bus.grant), 32'h1);
    bus.req = 2'b00;
    step(5);
    bus.req = 2'b10;
    base_grant = grant_cnt;
    wait_evt(1, 40, cyc);
    check("t3_rsp0", 32'(bus.rsp_valid), 32'h1);
    check("t3_no_early_grant", 32'(grant_cnt - base_grant), 0);
    wait_evt(0, 10, cyc);
    check("t3_grant1_lat", 32'(cyc), 2);
    check("t3_grant1", 32'(bus.grant), 32'h2);
    bus.req = 2'b00;

    // 6: one-cycle req[0] pulse while busy is withdrawn
    step(3);
    base_rsp = rsp_cnt;
    base_grant = grant_cnt;
    bus.req = 2'b01;
    step(1);
    bus.req = 2'b00;
    wait_evt(1, 40, cyc);
    check("t6_rsp1", 32'(bus.rsp_valid), 32'h2);
    check("t6_rsp1_m", 32'(bus.rsp_m), 32'h0202);
    step(20);
    check("t6_no_grant", 32'(grant_cnt - base_grant), 0);
    check("t6_one_rsp", 32'(rsp_cnt - base_rsp), 1);
    check("t6_idle", 32'(bus.busy), 0);

    // 4: async reset in BUSY aborts without a response
    set_ops(0, 7'h04, 15'h0010, 7'h04, 15'h0020);
    bus.req = 2'b01;
    wait_evt(0, 5, cyc);
    check("t4_grant", 32'(bus.grant), 32'h1);
    bus.req = 2'b00;
    step(5);
    base_rsp = rsp_cnt;
    #2;
    reset = 1'b1;
    #1;
    check("t4_rst_busy", 32'(bus.busy), 0);
    check("t4_rst_r1m", 32'(bus.fpu_r1m), 0);
    check("t4_rst_rsp_m", 32'(bus.rsp_m), 0);
    check("t4_rst_add", 32'(bus.fpu_add), 0);
    step(2);
    reset = 1'b0;
    step(15);
    check("t4_no_rsp", 32'(rsp_cnt - base_rsp), 0);
    bus.req = 2'b01;
    wait_evt(0, 5, cyc);
    check("t4_regrant_lat", 32'(cyc), 1);
    bus.req = 2'b00;
    wait_evt(1, 40, cyc);
    check("t4_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t4_rsp_m", 32'(bus.rsp_m), 32'h0030);

`ifdef FPU_ARB_TIMEOUT_EN
    // 5: fpu never returns idle, abort after 20 BUSY cycles
    step(2);
    hold_low = 1'b1;
    bus.req = 2'b01;
    wait_evt(0, 5, cyc);
    check("t5_grant", 32'(bus.grant), 32'h1);
    bus.req = 2'b00;
    wait_evt(1, 60, cyc);
    check("t5_rsp_lat", 32'(cyc), 23);
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("t5_rsp_err", 32'(bus.rsp_err), 1);
    check("t5_rsp_e", 32'(bus.rsp_e), 0);
    check("t5_rsp_m", 32'(bus.rsp_m), 0);
    hold_low = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
`endif

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
